// File: rtl/vliw_pkg.sv
// Shared widths and fill-engine state encoding for the VLIW front end.
package vliw_pkg;

    localparam int PC_W   = 28;
    localparam int PACK_W = 128;
    localparam int BUS_W  = 16;
    localparam int BEATS  = PACK_W / BUS_W;
    localparam int BEAT_W = $clog2(BEATS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_DONE,
        S_DRAIN
    } fill_state_e;

endpackage

// File: rtl/icache_fill.sv
// Instruction-cache miss fill engine: reads one 128-bit pack as eight 16-bit
// beats over a req/ack bus and strobes it into the icache for one cycle.
module icache_fill
    import vliw_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [PC_W-1:0]        curr_PC,
    input  logic                   cache_hit,
    input  logic                   fetch_en,
    input  logic                   invalidate,
    output logic [PACK_W-1:0]      new_entry,
    output logic                   entry_valid,
    output logic                   fill_busy,
    output logic                   mem_req,
    output logic [PC_W+BEAT_W-1:0] mem_addr,
    input  logic                   mem_ack,
    input  logic [BUS_W-1:0]       mem_rdata
);

    fill_state_e        state_q, state_d;
    logic [BEAT_W-1:0]  beat_q, beat_d;
    logic [PC_W-1:0]    fill_pc_q, fill_pc_d;
    logic [PACK_W-1:0]  new_entry_q, new_entry_d;

    always_comb begin
        state_d     = state_q;
        beat_d      = beat_q;
        fill_pc_d   = fill_pc_q;
        new_entry_d = new_entry_q;
        unique case (state_q)
            S_IDLE: begin
                if (fetch_en && !cache_hit && !invalidate) begin
                    fill_pc_d = curr_PC;
                    beat_d    = '0;
                    state_d   = S_FETCH;
                end
            end
            S_FETCH: begin
                if (mem_ack) begin
                    new_entry_d[beat_q*BUS_W +: BUS_W] = mem_rdata;
                    beat_d = beat_q + 1'b1;
                    // A flush coinciding with any ack, even the last, drops the pack.
                    if (invalidate)
                        state_d = S_IDLE;
                    else if (beat_q == BEAT_W'(BEATS - 1))
                        state_d = S_DONE;
                end else if (invalidate) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (mem_ack)
                    state_d = S_IDLE;
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            beat_q      <= '0;
            fill_pc_q   <= '0;
            new_entry_q <= '0;
        end else begin
            state_q     <= state_d;
            beat_q      <= beat_d;
            fill_pc_q   <= fill_pc_d;
            new_entry_q <= new_entry_d;
        end
    end

    // The icache tags with curr_PC, so a pack for a PC the core has left is dropped.
    assign entry_valid = (state_q == S_DONE) && !invalidate && (curr_PC == fill_pc_q);
    assign fill_busy   = (state_q != S_IDLE);
    assign mem_req     = (state_q == S_FETCH) || (state_q == S_DRAIN);
    assign mem_addr    = {fill_pc_q, beat_q};
    assign new_entry   = new_entry_q;

endmodule

// File: tb/tb_icache_fill.sv
// Self-checking bench for icache_fill: directed table, corner sequences and
// randomized traffic against a beat-counting reference model.
module tb_icache_fill;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [27:0]  curr_PC;
    logic         cache_hit, fetch_en, invalidate, mem_ack;
    logic [15:0]  mem_rdata;
    logic [127:0] new_entry;
    logic         entry_valid, fill_busy, mem_req;
    logic [30:0]  mem_addr;

    int checks = 0;
    int errors = 0;

    icache_fill dut (
        .clk(clk), .rst_n(rst_n), .curr_PC(curr_PC), .cache_hit(cache_hit),
        .fetch_en(fetch_en), .invalidate(invalidate), .new_entry(new_entry),
        .entry_valid(entry_valid), .fill_busy(fill_busy), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Reference model: fill in progress / draining / pack ready, plus words received.
    bit          m_fill, m_drain, m_done;
    int          m_k;
    logic [27:0] m_pc;
    logic [15:0] m_words [8];

    // Outputs sampled mid-cycle by step()
    logic         s_req, s_ev, s_busy;
    logic [30:0]  s_addr;
    logic [127:0] s_entry;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%h exp=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        m_fill = 0; m_drain = 0; m_done = 0; m_k = 0; m_pc = '0;
        for (int i = 0; i < 8; i++) m_words[i] = '0;
    endtask

    function automatic logic [127:0] model_entry();
        logic [127:0] e = '0;
        for (int i = 0; i < 8; i++) e = e | (128'(m_words[i]) << (16 * i));
        return e;
    endfunction

    task automatic model_clock(input logic fe, input logic hit, input logic inv,
                               input logic ack, input logic [27:0] pc, input logic [15:0] rd);
        if (m_done) begin
            m_done = 0;
        end else if (m_drain) begin
            if (ack) m_drain = 0;
        end else if (m_fill) begin
            if (ack) begin
                m_words[m_k] = rd;
                m_k++;
                if (inv) m_fill = 0;
                else if (m_k == 8) begin m_fill = 0; m_done = 1; end
            end else if (inv) begin
                m_fill = 0; m_drain = 1;
            end
        end else if (fe && !hit && !inv) begin
            m_fill = 1; m_k = 0; m_pc = pc;
        end
    endtask

    // Called at posedge+1: drive, compare against model mid-cycle, then clock.
    task automatic step(input logic fe, input logic hit, input logic inv,
                        input logic ack, input logic [27:0] pc, input logic [15:0] rd);
        logic [30:0] eaddr;
        fetch_en = fe; cache_hit = hit; invalidate = inv; mem_ack = ack;
        curr_PC = pc; mem_rdata = rd;
        #3;
        s_req = mem_req; s_ev = entry_valid; s_busy = fill_busy;
        s_addr = mem_addr; s_entry = new_entry;
        eaddr = {m_pc, 3'(m_k % 8)};
        chk("model_req",   128'(s_req),  128'(m_fill | m_drain));
        chk("model_busy",  128'(s_busy), 128'(m_fill | m_drain | m_done));
        chk("model_ev",    128'(s_ev),   128'(m_done && !inv && pc == m_pc));
        chk("model_addr",  128'(s_addr), 128'(eaddr));
        chk("model_entry", s_entry,      model_entry());
        @(posedge clk);
        model_clock(fe, hit, inv, ack, pc, rd);
        #1;
    endtask

    typedef struct {
        logic        fe, hit, ack;
        logic [27:0] pc;
        logic [15:0] rd;
        logic        e_req, e_busy, e_ev;
        logic [30:0] e_addr;
    } vec_t;

    vec_t        tbl [11];
    int          ev_cnt;
    logic [30:0] prev_addr;
    logic        prev_req, prev_ack, a;
    logic [127:0] exp_pack;
    logic [27:0] rpc;

    initial begin
        rst_n = 0; curr_PC = 28'h1234567; fetch_en = 1; cache_hit = 0;
        invalidate = 0; mem_ack = 0; mem_rdata = '0;
        model_reset();

        // Reset held with a pending miss: everything stays quiet
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req",   128'(mem_req),     128'(0));
        chk("rst_busy",  128'(fill_busy),   128'(0));
        chk("rst_ev",    128'(entry_valid), 128'(0));
        chk("rst_addr",  128'(mem_addr),    128'(0));
        chk("rst_entry", new_entry,         128'(0));
        rst_n = 1;
        step(1, 0, 0, 0, 28'h1234567, 0);
        chk("rst_fetch_req",  128'(mem_req),  128'(1));
        chk("rst_fetch_addr", 128'(mem_addr), 128'({28'h1234567, 3'd0}));
        step(1, 1, 0, 1, 28'h1234567, 16'hbeef);
        // Asynchronous reset mid-fill drops the request without a clock edge
        #1 rst_n = 0;
        #1;
        chk("arst_req",  128'(mem_req),   128'(0));
        chk("arst_busy", 128'(fill_busy), 128'(0));
        chk("arst_entry", new_entry,      128'(0));
        @(posedge clk); #1;
        rst_n = 1; model_reset();

        // Zero-wait fill of PC 0x10 from a table of vectors
        tbl[0] = '{1, 0, 0, 28'h10, 0, 0, 0, 0, 31'h0};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{1, 1, 1, 28'h10, 16'(16'h1000 + i - 1), 1, 1, 0, 31'(32'h80 + i - 1)};
        tbl[9]  = '{1, 1, 0, 28'h10, 0, 0, 1, 1, 31'h80};
        tbl[10] = '{1, 1, 0, 28'h10, 0, 0, 0, 0, 31'h80};
        for (int i = 0; i < 11; i++) begin
            step(tbl[i].fe, tbl[i].hit, 0, tbl[i].ack, tbl[i].pc, tbl[i].rd);
            chk($sformatf("tbl%0d_req", i),  128'(s_req),  128'(tbl[i].e_req));
            chk($sformatf("tbl%0d_busy", i), 128'(s_busy), 128'(tbl[i].e_busy));
            chk($sformatf("tbl%0d_ev", i),   128'(s_ev),   128'(tbl[i].e_ev));
            chk($sformatf("tbl%0d_addr", i), 128'(s_addr), 128'(tbl[i].e_addr));
            if (i == 9) begin
                exp_pack = '0;
                for (int b = 0; b < 8; b++) exp_pack[b*16 +: 16] = 16'(16'h1000 + b);
                chk("tbl_pack", s_entry, exp_pack);
            end
        end

        // Wait states: ack on every third cycle
        step(1, 0, 0, 0, 28'h30, 0);
        ev_cnt = 0; prev_req = 0; prev_ack = 0; prev_addr = '0;
        for (int c = 0; c < 60; c++) begin
            a = (c % 3 == 2);
            step(1, 1, 0, a, 28'h30, 16'($urandom));
            if (prev_req && s_req && !prev_ack)
                chk("ws_addr_stable", 128'(s_addr), 128'(prev_addr));
            ev_cnt += int'(s_ev);
            prev_req = s_req; prev_ack = a; prev_addr = s_addr;
            if (!s_busy) break;
        end
        chk("ws_ev_once", 128'(ev_cnt), 128'(1));
        chk("ws_idle", 128'(s_busy), 128'(0));

        // Invalidate while beat 3 is outstanding -> drain
        step(1, 0, 0, 0, 28'h40, 0);
        for (int b = 0; b < 3; b++) step(1, 1, 0, 1, 28'h40, 16'($urandom));
        step(1, 1, 1, 0, 28'h40, 0);
        for (int c = 0; c < 2; c++) begin
            step(1, 1, 0, 0, 28'h40, 0);
            chk("drain_req",  128'(s_req),  128'(1));
            chk("drain_addr", 128'(s_addr), 128'({28'h40, 3'd3}));
        end
        step(1, 1, 0, 1, 28'h40, 16'hdead);
        chk("drain_ack_req", 128'(s_req), 128'(1));
        step(1, 1, 0, 0, 28'h40, 0);
        chk("drain_idle", 128'(s_busy), 128'(0));
        chk("drain_no_ev", 128'(s_ev), 128'(0));

        // Invalidate together with the beat-7 ack
        step(1, 0, 0, 0, 28'h50, 0);
        for (int b = 0; b < 7; b++) step(1, 1, 0, 1, 28'h50, 16'($urandom));
        step(1, 1, 1, 1, 28'h50, 16'h7777);
        step(1, 1, 0, 0, 28'h50, 0);
        chk("inv7_idle", 128'(s_busy), 128'(0));
        chk("inv7_no_ev", 128'(s_ev), 128'(0));

        // Invalidate in the DONE cycle
        step(1, 0, 0, 0, 28'h60, 0);
        for (int b = 0; b < 8; b++) step(1, 1, 0, 1, 28'h60, 16'($urandom));
        step(1, 1, 1, 0, 28'h60, 0);
        chk("invd_busy", 128'(s_busy), 128'(1));
        chk("invd_no_ev", 128'(s_ev), 128'(0));

        // Core moves from 0x10 to 0x20 mid-fill
        step(1, 0, 0, 0, 28'h10, 0);
        for (int b = 0; b < 4; b++) step(1, 0, 0, 1, 28'h10, 16'($urandom));
        for (int b = 0; b < 4; b++) step(1, 0, 0, 1, 28'h20, 16'($urandom));
        step(1, 0, 0, 0, 28'h20, 0);
        chk("pcmv_no_ev", 128'(s_ev), 128'(0));
        chk("pcmv_done_busy", 128'(s_busy), 128'(1));
        step(1, 0, 0, 0, 28'h20, 0);
        chk("pcmv_idle", 128'(s_busy), 128'(0));
        step(1, 1, 0, 0, 28'h20, 0);
        chk("pcmv_new_req",  128'(s_req),  128'(1));
        chk("pcmv_new_addr", 128'(s_addr), 128'({28'h20, 3'd0}));

        // Randomized traffic against the model
        rpc = 28'h10;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 15) == 0)
                rpc = ($urandom_range(0, 1) != 0) ? 28'($urandom) : 28'($urandom_range(1, 3) << 4);
            step($urandom_range(0, 9) < 8, $urandom_range(0, 9) < 3,
                 $urandom_range(0, 39) == 0, $urandom_range(0, 9) < 4,
                 rpc, 16'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
